// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory-access stage between EX/MEM and MEM/WB. It turns an EX/MEM load or
//   store into a lane-aligned req/ack access on a variable-latency memory bus,
//   stalls upstream while the access is outstanding, detects misaligned or
//   illegal-size accesses, and registers the MEM/WB results, including the
//   shifted and extended load value.
//
// Ports
//   clk, Rst_n            clock, asynchronous active-low reset
//   dbg                   debug freeze: MEM/WB holds, a DONE access is held
//   EX_MEM_*              address/ALU result, store data, rs2/rd, control,
//                         one-hot load {ld,lwu,lhu,lbu,lw,lh,lb} and
//                         store {sd,sw,sh,sb} size selects
//   WB_res                writeback value, forwarded as store data
//   mem_req/we/addr/be/wdata, mem_ack, mem_rdata   memory handshake
//   mem_hold              stall to every upstream stage
//   MEM_WB_*              registered results, fault flag and fault address
module mem_access_stage #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                Rst_n,
  input  logic                dbg,
  input  logic [ADDR_W-1:0]   EX_MEM_alures,
  input  logic [XLEN-1:0]     EX_MEM_dout_rs2,
  input  logic [4:0]          EX_MEM_rs2,
  input  logic [4:0]          EX_MEM_rd,
  input  logic                EX_MEM_regwrite,
  input  logic                EX_MEM_memread,
  input  logic                EX_MEM_memwrite,
  input  logic [6:0]          EX_MEM_loadcntrl,
  input  logic [3:0]          EX_MEM_storecntrl,
  input  logic [XLEN-1:0]     WB_res,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_ack,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                mem_hold,
  output logic                MEM_WB_regwrite,
  output logic                MEM_WB_memread,
  output logic [4:0]          MEM_WB_rd,
  output logic [ADDR_W-1:0]   MEM_WB_alures,
  output logic [XLEN-1:0]     MEM_WB_memres,
  output logic                MEM_WB_fault,
  output logic [ADDR_W-1:0]   MEM_WB_fault_addr
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam bit RV32 = (XLEN == 32);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              req_we_q, req_we_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [NB-1:0]     req_be_q, req_be_d;
  logic [XLEN-1:0]   req_wdata_q, req_wdata_d;
  logic [XLEN-1:0]   ld_hold_q, ld_hold_d;

  logic              mwb_regwrite_q, mwb_regwrite_d;
  logic              mwb_memread_q, mwb_memread_d;
  logic [4:0]        mwb_rd_q, mwb_rd_d;
  logic [ADDR_W-1:0] mwb_alures_q, mwb_alures_d;
  logic [XLEN-1:0]   mwb_memres_q, mwb_memres_d;
  logic              mwb_fault_q, mwb_fault_d;
  logic [ADDR_W-1:0] mwb_fault_addr_q, mwb_fault_addr_d;

  logic            op, fault, misalign, enc_ok, wide_bad;
  logic            sz_b, sz_h, sz_w, sz_d, ld_sgn;
  logic [OFFW-1:0] off;
  logic [NB-1:0]   size_mask, be_c;
  logic [XLEN-1:0] st_src, wdata_c;
  logic [ADDR_W-1:0] addr_c;
  logic [XLEN-1:0] ld_sh, ld_mask, ld_ext;
  logic            ld_msb, fwd, issue, in_wait, wb_en;

  assign op  = EX_MEM_memread | EX_MEM_memwrite;
  assign off = EX_MEM_alures[OFFW-1:0];

  // Size decode. A store selects on storecntrl, otherwise loadcntrl; read and
  // write together is treated as a bad encoding.
  always_comb begin
    sz_b     = 1'b0;
    sz_h     = 1'b0;
    sz_w     = 1'b0;
    sz_d     = 1'b0;
    ld_sgn   = 1'b0;
    enc_ok   = 1'b0;
    wide_bad = 1'b0;
    if (EX_MEM_memwrite) begin
      {sz_d, sz_w, sz_h, sz_b} = EX_MEM_storecntrl;
      enc_ok   = $onehot(EX_MEM_storecntrl) & ~EX_MEM_memread;
      wide_bad = RV32 & EX_MEM_storecntrl[3];
    end else begin
      sz_b     = EX_MEM_loadcntrl[0] | EX_MEM_loadcntrl[3];
      sz_h     = EX_MEM_loadcntrl[1] | EX_MEM_loadcntrl[4];
      sz_w     = EX_MEM_loadcntrl[2] | EX_MEM_loadcntrl[5];
      sz_d     = EX_MEM_loadcntrl[6];
      ld_sgn   = |EX_MEM_loadcntrl[2:0];
      enc_ok   = $onehot(EX_MEM_loadcntrl);
      wide_bad = RV32 & (EX_MEM_loadcntrl[5] | EX_MEM_loadcntrl[6]);
    end
  end

  assign misalign = (sz_h & off[0]) | (sz_w & (|off[1:0])) | (sz_d & (|off));
  assign fault    = op & (~enc_ok | misalign | wide_bad);

  // Store path: forward the WB value when it targets rs2 (never x0), then
  // shift data and byte enables into the addressed lanes.
  assign fwd    = mwb_regwrite_q & (mwb_rd_q == EX_MEM_rs2) & (mwb_rd_q != 5'd0);
  assign st_src = fwd ? WB_res : EX_MEM_dout_rs2;
  assign size_mask = sz_d ? '1 : sz_w ? NB'(4'hF) : sz_h ? NB'(2'h3) : NB'(1'b1);
  assign wdata_c   = st_src << {off, 3'b000};
  assign be_c      = EX_MEM_memwrite ? (size_mask << off) : '0;
  assign addr_c    = {EX_MEM_alures[ADDR_W-1:OFFW], {OFFW{1'b0}}};

  // Load path: bring the addressed lane to bit 0, keep the access width and
  // fill the rest with the sign (lb/lh/lw) or zeros. ld keeps everything.
  assign ld_sh   = mem_rdata >> {off, 3'b000};
  assign ld_mask = sz_b ? XLEN'(8'hFF) : sz_h ? XLEN'(16'hFFFF) :
                   sz_w ? XLEN'(32'hFFFF_FFFF) : '1;
  assign ld_msb  = sz_b ? ld_sh[7] : sz_h ? ld_sh[15] : ld_sh[31];
  assign ld_ext  = (ld_sh & ld_mask) | ((ld_sgn & ld_msb) ? ~ld_mask : '0);

  // Rst_n gating keeps the combinational request quiet while reset is held,
  // even if EX/MEM still presents an access.
  assign issue   = (state_q == S_IDLE) & op & ~fault & Rst_n;
  assign in_wait = (state_q == S_WAIT);

  assign mem_req   = issue | in_wait;
  assign mem_we    = issue ? EX_MEM_memwrite : (in_wait & req_we_q);
  assign mem_addr  = issue ? addr_c  : in_wait ? req_addr_q  : '0;
  assign mem_be    = issue ? be_c    : in_wait ? req_be_q    : '0;
  assign mem_wdata = issue ? wdata_c : in_wait ? req_wdata_q : '0;
  assign mem_hold  = (issue & ~mem_ack) | in_wait;

  assign wb_en = ~dbg & ~mem_hold;

  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_be_d    = req_be_q;
    req_wdata_d = req_wdata_q;
    ld_hold_d   = ld_hold_q;
    case (state_q)
      S_IDLE: if (issue && !mem_ack) begin
        // Freeze the request so WAIT is immune to forwarding changes.
        state_d     = S_WAIT;
        req_we_d    = EX_MEM_memwrite;
        req_addr_d  = addr_c;
        req_be_d    = be_c;
        req_wdata_d = wdata_c;
      end
      S_WAIT: if (mem_ack) begin
        // EX/MEM is stalled, so the current size/offset still describe it.
        state_d   = S_DONE;
        ld_hold_d = ld_ext;
      end
      S_DONE: if (!dbg) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mwb_regwrite_d   = mwb_regwrite_q;
    mwb_memread_d    = mwb_memread_q;
    mwb_rd_d         = mwb_rd_q;
    mwb_alures_d     = mwb_alures_q;
    mwb_memres_d     = mwb_memres_q;
    mwb_fault_d      = mwb_fault_q;
    mwb_fault_addr_d = mwb_fault_addr_q;
    if (wb_en) begin
      mwb_regwrite_d   = EX_MEM_regwrite & ~fault;
      mwb_memread_d    = EX_MEM_memread;
      mwb_rd_d         = EX_MEM_rd;
      mwb_alures_d     = EX_MEM_alures;
      mwb_fault_d      = fault;
      mwb_fault_addr_d = fault ? EX_MEM_alures : '0;
      mwb_memres_d     = '0;
      // Unstalled in IDLE a good load can only be a same-cycle ack.
      if (EX_MEM_memread && !fault)
        mwb_memres_d = (state_q == S_DONE) ? ld_hold_q : ld_ext;
    end
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q          <= S_IDLE;
      req_we_q         <= 1'b0;
      req_addr_q       <= '0;
      req_be_q         <= '0;
      req_wdata_q      <= '0;
      ld_hold_q        <= '0;
      mwb_regwrite_q   <= 1'b0;
      mwb_memread_q    <= 1'b0;
      mwb_rd_q         <= '0;
      mwb_alures_q     <= '0;
      mwb_memres_q     <= '0;
      mwb_fault_q      <= 1'b0;
      mwb_fault_addr_q <= '0;
    end else begin
      state_q          <= state_d;
      req_we_q         <= req_we_d;
      req_addr_q       <= req_addr_d;
      req_be_q         <= req_be_d;
      req_wdata_q      <= req_wdata_d;
      ld_hold_q        <= ld_hold_d;
      mwb_regwrite_q   <= mwb_regwrite_d;
      mwb_memread_q    <= mwb_memread_d;
      mwb_rd_q         <= mwb_rd_d;
      mwb_alures_q     <= mwb_alures_d;
      mwb_memres_q     <= mwb_memres_d;
      mwb_fault_q      <= mwb_fault_d;
      mwb_fault_addr_q <= mwb_fault_addr_d;
    end
  end

  assign MEM_WB_regwrite   = mwb_regwrite_q;
  assign MEM_WB_memread    = mwb_memread_q;
  assign MEM_WB_rd         = mwb_rd_q;
  assign MEM_WB_alures     = mwb_alures_q;
  assign MEM_WB_memres     = mwb_memres_q;
  assign MEM_WB_fault      = mwb_fault_q;
  assign MEM_WB_fault_addr = mwb_fault_addr_q;
endmodule
